// File: rtl/seg7_reader.sv
// seg7_reader: watches an active-low 7-segment bus, waits for the pattern to
// be stable, decodes it back to a 3-bit digit code and offers it on a
// valid/ready handshake. Stable patterns that match no code raise a one-cycle
// bad_pattern pulse instead.
//
// Parameters:
//   STABLE_CYCLES  - consecutive matching samples before evaluation (1..255)
//   REPORT_REPEATS - 0: drop a report equal to the last accepted code
//                    1: report every newly stable pattern
//
// Optional feature macro: SEG7_READER_ERR_CNT_EN
//   defined     - err_count is a saturating count of bad_pattern pulses
//   not defined - err_count is tied to 8'h00
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   seg_in      in   [6:0] segment bus, active-low
//   data_out    out  [2:0] decoded digit code
//   valid       out  data_out holds a new code
//   ready       in   downstream accepts (transfer on valid && ready)
//   bad_pattern out  one-cycle pulse: stable pattern matched no code
//   err_count   out  [7:0] saturating bad_pattern count
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          REPORT_REPEATS = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [2:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       bad_pattern,
  output logic [7:0] err_count
);

  localparam int unsigned SegW  = 7;
  localparam int unsigned CodeW = 3;
  localparam int unsigned CntW  = 8;
  localparam int unsigned ErrW  = 8;

  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SegW-1:0]   samp_q, samp_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              dirty_q, dirty_d;
  logic              last_vld_q, last_vld_d;
  logic [CodeW-1:0]  last_code_q, last_code_d;
  logic [CodeW-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              bad_q, bad_d;

  logic              dec_hit;
  logic [CodeW-1:0]  dec_code;
  logic              eval_now;

  // Exact 7-bit match against the decoder's output table.
  function automatic logic [CodeW:0] decode(input logic [SegW-1:0] seg);
    logic [CodeW:0] res;
    res = '0;
    case (seg)
      7'h01:   res = {1'b1, 3'd0};
      7'h4f:   res = {1'b1, 3'd1};
      7'h12:   res = {1'b1, 3'd2};
      7'h06:   res = {1'b1, 3'd3};
      7'h4c:   res = {1'b1, 3'd4};
      7'h24:   res = {1'b1, 3'd5};
      7'h60:   res = {1'b1, 3'd6};
      7'h0f:   res = {1'b1, 3'd7};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Decode the registered sample; it equals seg_in whenever it is evaluated.
  always_comb begin
    {dec_hit, dec_code} = decode(samp_q);
  end

  // A pattern is ready for evaluation once it has been seen unchanged long enough.
  always_comb begin
    eval_now = dirty_q && (cnt_q == CntMax) && (samp_q == seg_in);
  end

  // Next-state logic: sampler runs in both states, FSM handles report/handshake.
  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    cnt_d       = cnt_q;
    dirty_d     = dirty_q;
    last_vld_d  = last_vld_q;
    last_code_d = last_code_q;
    data_d      = data_q;
    valid_d     = valid_q;
    bad_d       = 1'b0;

    if (seg_in != samp_q) begin
      samp_d  = seg_in;
      cnt_d   = '0;
      dirty_d = 1'b1;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end

    case (state_q)
      IDLE: begin
        if (eval_now) begin
          dirty_d = 1'b0;
          if (dec_hit) begin
            // A known code equal to the last accepted one is dropped unless repeats are wanted.
            if (REPORT_REPEATS || !last_vld_q || (dec_code != last_code_q)) begin
              data_d  = dec_code;
              valid_d = 1'b1;
              state_d = HOLD;
            end
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (valid_q && ready) begin
          valid_d     = 1'b0;
          last_code_d = data_q;
          last_vld_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      samp_q      <= 7'h7f;
      cnt_q       <= '0;
      dirty_q     <= 1'b0;
      last_vld_q  <= 1'b0;
      last_code_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      cnt_q       <= cnt_d;
      dirty_q     <= dirty_d;
      last_vld_q  <= last_vld_d;
      last_code_q <= last_code_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      bad_q       <= bad_d;
    end
  end

  assign data_out    = data_q;
  assign valid       = valid_q;
  assign bad_pattern = bad_q;

`ifdef SEG7_READER_ERR_CNT_EN
  logic [ErrW-1:0] err_q, err_d;

  // Counts alongside the bad_pattern pulse, sticking at all-ones.
  always_comb begin
    err_d = err_q;
    if (bad_d && (err_q != {ErrW{1'b1}})) begin
      err_d = err_q + ErrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = ErrW'(0);
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Testbench for seg7_reader: three instances (repeat suppression on/off and a
// one-cycle stability window) share the stimulus; a run-length based model
// predicts every output each cycle, plus directed literal checks.
module tb_seg7_reader;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'h7f;
  logic       ready = 1'b1;

  logic [2:0] o_data  [NDUT];
  logic       o_valid [NDUT];
  logic       o_bad   [NDUT];
  logic [7:0] o_err   [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_reader #(.STABLE_CYCLES(4), .REPORT_REPEATS(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .data_out(o_data[0]), .valid(o_valid[0]),
    .ready(ready), .bad_pattern(o_bad[0]), .err_count(o_err[0]));

  seg7_reader #(.STABLE_CYCLES(4), .REPORT_REPEATS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .data_out(o_data[1]), .valid(o_valid[1]),
    .ready(ready), .bad_pattern(o_bad[1]), .err_count(o_err[1]));

  seg7_reader #(.STABLE_CYCLES(1), .REPORT_REPEATS(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .data_out(o_data[2]), .valid(o_valid[2]),
    .ready(ready), .bad_pattern(o_bad[2]), .err_count(o_err[2]));

  function automatic int stab(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic bit rep(input int k);
    return k == 1;
  endfunction

`ifdef SEG7_READER_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- reference model ----------------
  logic [6:0] tbl [8] = '{7'h01, 7'h4f, 7'h12, 7'h06, 7'h4c, 7'h24, 7'h60, 7'h0f};

  logic [6:0] m_prev  [NDUT];  // last value seen on the bus
  int         m_run   [NDUT];  // edges the current value has been present
  bit         m_pend  [NDUT];  // current run not yet evaluated
  bit         m_valid [NDUT];
  logic [2:0] m_data  [NDUT];
  bit         m_bad   [NDUT];
  int         m_err   [NDUT];
  bit         m_lvld  [NDUT];
  logic [2:0] m_lcode [NDUT];

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_prev[k] = 7'h7f; m_run[k] = 0; m_pend[k] = 1'b0;
      m_valid[k] = 1'b0; m_data[k] = 3'd0; m_bad[k] = 1'b0; m_err[k] = 0;
      m_lvld[k] = 1'b0; m_lcode[k] = 3'd0;
    end
  endtask

  task automatic model_step(input int k, input logic [6:0] s, input logic r);
    int  code;
    bit  stable;
    code   = -1;
    stable = m_pend[k] && (s == m_prev[k]) && (m_run[k] >= stab(k) + 1);
    m_bad[k] = 1'b0;
    if (m_valid[k]) begin
      if (r) begin
        m_valid[k] = 1'b0;
        m_lcode[k] = m_data[k];
        m_lvld[k]  = 1'b1;
      end
    end else if (stable) begin
      m_pend[k] = 1'b0;
      for (int i = 0; i < 8; i++) if (tbl[i] == s) code = i;
      if (code < 0) begin
        m_bad[k] = 1'b1;
        if (ERR_EN && m_err[k] < 255) m_err[k]++;
      end else if (rep(k) || !m_lvld[k] || (3'(code) != m_lcode[k])) begin
        m_valid[k] = 1'b1;
        m_data[k]  = 3'(code);
      end
    end
    if (s != m_prev[k]) begin
      m_prev[k] = s; m_run[k] = 1; m_pend[k] = 1'b1;
    end else if (m_run[k] < 1000) begin
      m_run[k]++;
    end
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int k = 0; k < NDUT; k++) model_step(k, seg_in, ready);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      chk("valid", k, 32'(o_valid[k]), 32'(m_valid[k]));
      chk("data_out", k, 32'(o_data[k]), 32'(m_data[k]));
      chk("bad_pattern", k, 32'(o_bad[k]), 32'(m_bad[k]));
      chk("err_count", k, 32'(o_err[k]), 32'(m_err[k]));
    end
  end

  // ---------------- stimulus ----------------
  int         npulse [NDUT];
  int         nbad   [NDUT];
  logic [2:0] lastd  [NDUT];

  task automatic clr();
    for (int k = 0; k < NDUT; k++) begin
      npulse[k] = 0; nbad[k] = 0; lastd[k] = 3'd0;
    end
  endtask

  // Hold a pattern for n edges, tallying valid cycles and bad pulses.
  task automatic hold(input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      seg_in = s;
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (o_valid[k]) begin npulse[k]++; lastd[k] = o_data[k]; end
        if (o_bad[k]) nbad[k]++;
      end
    end
  endtask

  int hold_left;
  logic [6:0] rnd_seg;

  initial begin
    // 1: reset with the bus blank, no output while it stays blank
    seg_in = 7'h7f; ready = 1'b1; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clr();
    hold(7'h7f, 10);
    chk("t1_valid", 0, 32'(o_valid[0]), 32'd0);
    chk("t1_data", 0, 32'(o_data[0]), 32'd0);
    chk("t1_err", 0, 32'(o_err[0]), 32'd0);
    chk("t1_pulses", 0, 32'(npulse[0]), 32'd0);
    chk("t1_bad", 0, 32'(nbad[0]), 32'd0);

    // 2: first report appears after the 6th edge, for one cycle
    seg_in = 7'h12;
    repeat (5) @(negedge clk);
    chk("t2_early", 0, 32'(o_valid[0]), 32'd0);
    @(negedge clk);
    chk("t2_valid", 0, 32'(o_valid[0]), 32'd1);
    chk("t2_data", 0, 32'(o_data[0]), 32'd2);
    @(negedge clk);
    chk("t2_drop", 0, 32'(o_valid[0]), 32'd0);

    // 3: short glitches produce nothing, only the settled 3 is reported
    clr();
    hold(7'h7f, 1);
    hold(7'h12, 3);
    hold(7'h06, 8);
    chk("t3_pulses", 0, 32'(npulse[0]), 32'd1);
    chk("t3_data", 0, 32'(lastd[0]), 32'd3);

    // 4: return to the same code after a blank gap
    hold(7'h4c, 8);
    clr();
    hold(7'h7f, 2);
    hold(7'h4c, 8);
    chk("t4_suppress", 0, 32'(npulse[0]), 32'd0);
    chk("t4_repeat", 1, 32'(npulse[1]), 32'd1);
    chk("t4_repeat_data", 1, 32'(lastd[1]), 32'd4);

    // 5: backpressure freezes the output, queued pattern follows the handshake
    ready = 1'b0;
    seg_in = 7'h24;
    repeat (6) @(negedge clk);
    chk("t5_valid", 0, 32'(o_valid[0]), 32'd1);
    chk("t5_data", 0, 32'(o_data[0]), 32'd5);
    seg_in = 7'h0f;
    repeat (10) @(negedge clk);
    chk("t5_held_valid", 0, 32'(o_valid[0]), 32'd1);
    chk("t5_held_data", 0, 32'(o_data[0]), 32'd5);
    ready = 1'b1;
    @(negedge clk);
    chk("t5_accept", 0, 32'(o_valid[0]), 32'd0);
    ready = 1'b0;
    @(negedge clk);
    chk("t5_next_valid", 0, 32'(o_valid[0]), 32'd1);
    chk("t5_next_data", 0, 32'(o_data[0]), 32'd7);
    ready = 1'b1;
    @(negedge clk);

    // 6: an unknown pattern pulses once; many of them saturate the counter
    clr();
    hold(7'h00, 20);
    chk("t6_bad_once", 0, 32'(nbad[0]), 32'd1);
    chk("t6_no_valid", 0, 32'(npulse[0]), 32'd0);
    chk("t6_err", 0, 32'(o_err[0]), ERR_EN ? 32'd1 : 32'd0);
    for (int i = 0; i < 300; i++) hold(((i % 2) == 0) ? 7'h7f : 7'h00, 6);
    chk("t6_bad_total", 0, 32'(nbad[0]), 32'd301);
    chk("t6_err_sat", 0, 32'(o_err[0]), ERR_EN ? 32'hff : 32'd0);

    // Reset while a code is held drops valid at once
    ready = 1'b0;
    seg_in = 7'h60;
    repeat (6) @(negedge clk);
    chk("rst_pre_valid", 0, 32'(o_valid[0]), 32'd1);
    chk("rst_pre_data", 0, 32'(o_data[0]), 32'd6);
    #2 rst_n = 1'b0;
    #1 chk("rst_valid", 0, 32'(o_valid[0]), 32'd0);
    chk("rst_err", 0, 32'(o_err[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model
    hold_left = 0;
    rnd_seg = 7'h7f;
    for (int i = 0; i < 4000; i++) begin
      if (hold_left == 0) begin
        case ($urandom_range(0, 3))
          0, 1: rnd_seg = tbl[$urandom_range(0, 7)];
          2:    rnd_seg = 7'($urandom);
          default: rnd_seg = rnd_seg;
        endcase
        hold_left = $urandom_range(1, 9);
      end
      seg_in = rnd_seg;
      hold_left--;
      ready = ($urandom_range(0, 3) != 0);
      if (!rst_n) begin
        rst_n = 1'b1;
        @(negedge clk);
      end else if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
